// File: rtl/image_buffer.sv
// Byte-stream image assembler: collects NUM_BYTES bytes into a parallel image word
// and holds it until buffer_clear. Optional sticky overflow flag: IMAGE_BUFFER_OVERFLOW_FLAG_EN.
module image_buffer #(
  parameter int IMG_BITS = 904,
  parameter int BYTE_W   = 8,
  localparam int NUM_BYTES = IMG_BITS / BYTE_W,
  localparam int CNT_W     = $clog2(NUM_BYTES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BYTE_W-1:0]   data_in,
  input  logic                data_valid,
  output logic                data_ready,
  input  logic                buffer_clear,
  output logic [IMG_BITS-1:0] img_out,
  output logic                img_buffer_full,
`ifdef IMAGE_BUFFER_OVERFLOW_FLAG_EN
  output logic                overflow,
`endif
  output logic [CNT_W-1:0]    byte_count
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t state;
  logic   accept;

  // Handshake: a byte transfers on a rising edge where data_valid && data_ready.
  // data_ready drops while FULL and in any cycle where buffer_clear is asserted,
  // so a clear always wins over a simultaneous byte.
  assign data_ready = (state != FULL) && !buffer_clear;
  assign accept     = data_valid && data_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= EMPTY;
      img_out         <= '0;
      img_buffer_full <= 1'b0;
      byte_count      <= '0;
`ifdef IMAGE_BUFFER_OVERFLOW_FLAG_EN
      overflow        <= 1'b0;
`endif
    end else if (buffer_clear) begin
      state           <= EMPTY;
      img_out         <= '0;
      img_buffer_full <= 1'b0;
      byte_count      <= '0;
`ifdef IMAGE_BUFFER_OVERFLOW_FLAG_EN
      overflow        <= 1'b0;
`endif
    end else begin
      case (state)
        EMPTY, FILLING: begin
          if (accept) begin
            // Direct placement by index: unwritten bytes keep their cleared value.
            for (int k = 0; k < NUM_BYTES; k++) begin
              if (byte_count == CNT_W'(k))
                img_out[IMG_BITS-1-BYTE_W*k -: BYTE_W] <= data_in;
            end
            byte_count <= byte_count + CNT_W'(1);
            if (byte_count == CNT_W'(NUM_BYTES - 1)) begin
              state           <= FULL;
              img_buffer_full <= 1'b1;
            end else begin
              state <= FILLING;
            end
          end
        end
        FULL: begin
`ifdef IMAGE_BUFFER_OVERFLOW_FLAG_EN
          if (data_valid)
            overflow <= 1'b1;
`endif
        end
        default: begin
          state           <= EMPTY;
          img_out         <= '0;
          img_buffer_full <= 1'b0;
          byte_count      <= '0;
        end
      endcase
    end
  end

`ifdef IMAGE_BUFFER_OVERFLOW_FLAG_EN
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && state == FULL && data_valid && !buffer_clear)
      $display("[IMAGE_BUFFER] @%0t overflow byte=%h", $time, data_in);
  end
`endif
`endif

endmodule

// File: tb/tb_image_buffer.sv
// Randomized bench for image_buffer: a queue of accepted bytes is the reference image,
// and every cycle the DUT outputs are compared with what that queue implies.
module tb_image_buffer;

  localparam int IMG_BITS  = 904;
  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = 113;
  localparam int CNT_W     = 7;

  logic                clk;
  logic                rst;
  logic [BYTE_W-1:0]   data_in;
  logic                data_valid;
  logic                data_ready;
  logic                buffer_clear;
  logic [IMG_BITS-1:0] img_out;
  logic                img_buffer_full;
  logic [CNT_W-1:0]    byte_count;
`ifdef IMAGE_BUFFER_OVERFLOW_FLAG_EN
  logic                overflow;
  bit                  exp_ovf;
`endif

  // Scoreboard: the bytes accepted since the last clear/reset, in arrival order.
  logic [BYTE_W-1:0] exp_q[$];

  int n_vec;
  int n_err;

  image_buffer dut (
    .clk             (clk),
    .rst             (rst),
    .data_in         (data_in),
    .data_valid      (data_valid),
    .data_ready      (data_ready),
    .buffer_clear    (buffer_clear),
    .img_out         (img_out),
    .img_buffer_full (img_buffer_full),
`ifdef IMAGE_BUFFER_OVERFLOW_FLAG_EN
    .overflow        (overflow),
`endif
    .byte_count      (byte_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [IMG_BITS-1:0] got,
                       input logic [IMG_BITS-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [IMG_BITS-1:0] model_img();
    logic [IMG_BITS-1:0] r;
    r = '0;
    foreach (exp_q[i]) r[IMG_BITS-1-BYTE_W*i -: BYTE_W] = exp_q[i];
    return r;
  endfunction

  function automatic bit model_full();
    return exp_q.size() == NUM_BYTES;
  endfunction

  task automatic check_outputs(input string where);
    check({where, ".img_out"}, img_out, model_img());
    check({where, ".byte_count"}, IMG_BITS'(byte_count), IMG_BITS'(exp_q.size()));
    check({where, ".full"}, IMG_BITS'(img_buffer_full), IMG_BITS'(model_full()));
`ifdef IMAGE_BUFFER_OVERFLOW_FLAG_EN
    check({where, ".overflow"}, IMG_BITS'(overflow), IMG_BITS'(exp_ovf));
`endif
  endtask

  task automatic model_clear();
    exp_q.delete();
`ifdef IMAGE_BUFFER_OVERFLOW_FLAG_EN
    exp_ovf = 1'b0;
`endif
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive after the falling edge, check ready before the rising
  // edge, advance the model on the rising edge, check registered outputs 1ns later.
  task automatic cycle(input bit v, input logic [BYTE_W-1:0] d, input bit c);
    bit exp_ready;
    @(negedge clk);
    data_valid   = v;
    data_in      = d;
    buffer_clear = c;
    #1;
    exp_ready = !model_full() && !c;
    check("data_ready", IMG_BITS'(data_ready), IMG_BITS'(exp_ready));
    @(posedge clk);
    if (c) begin
      model_clear();
    end else if (v) begin
      if (model_full()) begin
`ifdef IMAGE_BUFFER_OVERFLOW_FLAG_EN
        exp_ovf = 1'b1;
`endif
      end else begin
        exp_q.push_back(d);
      end
    end
    #1;
    check_outputs("cyc");
  endtask

  task automatic idle();
    cycle(1'b0, BYTE_W'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic send(input logic [BYTE_W-1:0] d, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    for (int g = 0; g < gap; g++) idle();
    cycle(1'b1, d, 1'b0);
  endtask

  task automatic clear_pulse();
    cycle(1'b0, 8'h00, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    exp_q.delete();
`ifdef IMAGE_BUFFER_OVERFLOW_FLAG_EN
    exp_ovf = 1'b0;
`endif
    rst          = 1'b1;
    data_in      = '0;
    data_valid   = 1'b0;
    buffer_clear = 1'b0;
    #12;
    check_outputs("reset");
    check("reset.data_ready", IMG_BITS'(data_ready), IMG_BITS'(1'b1));
    @(negedge clk);
    rst = 1'b0;

    // Basic fill with byte k = k, back to back.
    for (int k = 0; k < NUM_BYTES; k++) begin
      cycle(1'b1, BYTE_W'(k), 1'b0);
      if (k == NUM_BYTES - 2)
        check("basic.not_full_early", IMG_BITS'(img_buffer_full), '0);
    end
    check("basic.top_byte", IMG_BITS'(img_out[903:896]), IMG_BITS'(8'h00));
    check("basic.byte1", IMG_BITS'(img_out[895:888]), IMG_BITS'(8'h01));
    check("basic.last_byte", IMG_BITS'(img_out[7:0]), IMG_BITS'(8'h70));
    check("basic.count", IMG_BITS'(byte_count), IMG_BITS'(113));
    check("basic.full", IMG_BITS'(img_buffer_full), IMG_BITS'(1'b1));

    // Write while full: bytes are dropped.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'hAA, 1'b0);
    check("full.last_byte_held", IMG_BITS'(img_out[7:0]), IMG_BITS'(8'h70));
`ifdef IMAGE_BUFFER_OVERFLOW_FLAG_EN
    check("full.overflow", IMG_BITS'(overflow), IMG_BITS'(1'b1));
`endif

    // Gapped fill of all-ones.
    clear_pulse();
    for (int k = 0; k < NUM_BYTES; k++) send(8'hFF, 3);
    check("gapped.all_ones", img_out, {IMG_BITS{1'b1}});

    // Clear coinciding with a valid byte at byte_count = 50.
    clear_pulse();
    for (int k = 0; k < 50; k++) send(BYTE_W'($urandom_range(0, 255)), 1);
    check("clr.count50", IMG_BITS'(byte_count), IMG_BITS'(50));
    cycle(1'b1, 8'h3C, 1'b1);
    check("clr.img_zero", img_out, '0);
    cycle(1'b1, 8'h5A, 1'b0);
    check("clr.next_at_top", IMG_BITS'(img_out[903:896]), IMG_BITS'(8'h5A));

    // Asynchronous reset between clock edges at byte_count = 60.
    clear_pulse();
    for (int k = 0; k < 60; k++) send(BYTE_W'($urandom_range(0, 255)), 1);
    @(negedge clk);
    data_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    check_outputs("async_rst");
    check("async_rst.data_ready", IMG_BITS'(data_ready), IMG_BITS'(1'b1));
    #1;
    rst = 1'b0;
    for (int k = 0; k < NUM_BYTES; k++) send(BYTE_W'($urandom_range(0, 255)), 1);
    check("after_rst.full", IMG_BITS'(img_buffer_full), IMG_BITS'(1'b1));

    // Refill after clear with byte k = 8'h80 ^ k.
    clear_pulse();
    for (int k = 0; k < NUM_BYTES; k++) send(8'h80 ^ BYTE_W'(k), 2);
    check("refill.top", IMG_BITS'(img_out[903:896]), IMG_BITS'(8'h80));
    check("refill.last", IMG_BITS'(img_out[7:0]), IMG_BITS'(8'hF0));

    // Random mix of valid/clear traffic.
    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(0, 3) != 0), BYTE_W'($urandom_range(0, 255)),
            ($urandom_range(0, 199) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within bound");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
